// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for the 32-bit XNOR LFSR stream: self-seeds from the first
// usable word, locks after LOCK_COUNT correct predictions, then counts words and errors.
module lfsr_seq_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_LIMIT  = 3,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      word_count,
  output logic [31:0]      expected
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int CW = $clog2(ERR_LIMIT + 1);
  localparam logic [MW-1:0] LC_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [CW-1:0] EL_LAST = CW'(ERR_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t        state;
  logic [MW-1:0] match_cnt;
  logic [CW-1:0] consec_err;

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return {x[30:0], x[31] ~^ x[21] ~^ x[1] ~^ x[0]};
  endfunction

  wire hit      = (in_data == expected);
  wire all_ones = (in_data == 32'hFFFF_FFFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      word_count <= '0;
      expected   <= '0;
      match_cnt  <= '0;
      consec_err <= '0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && !all_ones) begin
            expected  <= lfsr_next(in_data);
            match_cnt <= '0;
            state     <= LOCKING;
          end
        end
        LOCKING: begin
          if (in_valid) begin
            if (hit) begin
              expected  <= lfsr_next(in_data);
              match_cnt <= match_cnt + 1'b1;
              if (match_cnt == LC_LAST) begin
                state      <= LOCKED;
                locked     <= 1'b1;
                consec_err <= '0;
              end
            end else begin
              // a miss restarts acquisition from the word just seen
              match_cnt <= '0;
              if (all_ones) state <= IDLE;
              else expected <= lfsr_next(in_data);
            end
          end
        end
        LOCKED: begin
          if (in_valid) begin
            word_count <= word_count + 32'd1;
            // prediction free-runs so one corrupted word costs one error
            expected   <= lfsr_next(expected);
            if (hit) begin
              consec_err <= '0;
            end else begin
              err_pulse  <= 1'b1;
              consec_err <= consec_err + 1'b1;
              if (err_count != {ERR_W{1'b1}}) err_count <= err_count + 1'b1;
              if (consec_err == EL_LAST) begin
                locked <= 1'b0;
                state  <= IDLE;
              end
            end
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
      if (clear) begin
        err_count  <= '0;
        word_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: directed scenarios plus random corrupted streams,
// every output compared each cycle against a behavioural model.
module tb_lfsr_seq_checker;
  localparam int LC = 4;
  localparam int EL = 3;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          clear;
  logic          locked;
  logic          err_pulse;
  logic [EW-1:0] err_count;
  logic [31:0]   word_count;
  logic [31:0]   expected;

  int errors = 0;
  int checks = 0;

  lfsr_seq_checker #(.LOCK_COUNT(LC), .ERR_LIMIT(EL), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .word_count(word_count), .expected(expected)
  );

  always #5 clk = ~clk;

  // model state: mode 0=searching for seed, 1=acquiring, 2=tracking
  int          m_mode, m_hits, m_run_err, m_ecnt;
  logic        m_lock, m_pulse;
  logic [31:0] m_exp, m_wcnt;

  function automatic logic [31:0] ref_next(input logic [31:0] x);
    logic p;
    p = ^(x & 32'h8020_0003);
    return (x << 1) | {31'd0, ~p};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_hits = 0; m_run_err = 0; m_ecnt = 0;
    m_lock = 0; m_pulse = 0; m_exp = '0; m_wcnt = '0;
  endtask

  task automatic model_step(input logic v, input logic [31:0] d, input logic c);
    m_pulse = 0;
    if (v) begin
      if (m_mode == 0) begin
        if (d != 32'hFFFF_FFFF) begin m_exp = ref_next(d); m_hits = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (d == m_exp) begin
          m_exp = ref_next(d);
          m_hits++;
          if (m_hits == LC) begin m_mode = 2; m_lock = 1; m_run_err = 0; end
        end else begin
          m_hits = 0;
          if (d == 32'hFFFF_FFFF) m_mode = 0;
          else m_exp = ref_next(d);
        end
      end else begin
        m_wcnt = m_wcnt + 1;
        if (d == m_exp) m_run_err = 0;
        else begin
          m_pulse = 1;
          m_run_err++;
          if (m_ecnt < (1 << EW) - 1) m_ecnt++;
          if (m_run_err == EL) begin m_lock = 0; m_mode = 0; end
        end
        m_exp = ref_next(m_exp);
      end
    end
    if (c) begin m_ecnt = 0; m_wcnt = '0; end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".locked"},     32'(locked),    32'(m_lock));
    chk({tag, ".err_pulse"},  32'(err_pulse), 32'(m_pulse));
    chk({tag, ".err_count"},  32'(err_count), 32'(m_ecnt));
    chk({tag, ".word_count"}, word_count,     m_wcnt);
    chk({tag, ".expected"},   expected,       m_exp);
  endtask

  task automatic step(input string tag, input logic v, input logic [31:0] d, input logic c);
    in_valid = v; in_data = d; clear = c;
    @(posedge clk);
    model_step(v, d, c);
    #1;
    compare_all(tag);
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    compare_all("rst");
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] src, d;
    logic        v, c;
    int          r;
    rst = 1'b1; in_valid = 0; in_data = '0; clear = 0;
    model_reset();
    #12;
    chk("reset.locked", 32'(locked), 32'd0);
    chk("reset.expected", expected, 32'd0);
    compare_all("reset");
    @(negedge clk); rst = 1'b0;

    // 1: acquire lock from seed 1
    step("t1", 1, 32'h1, 0);
    step("t1", 1, 32'h2, 0);
    step("t1", 1, 32'h4, 0);
    step("t1", 1, 32'h9, 0);
    chk("t1.not_yet", 32'(locked), 32'd0);
    step("t1", 1, 32'h12, 0);
    chk("t1.locked", 32'(locked), 32'd1);
    chk("t1.expected", expected, 32'h24);
    step("t1.idle", 0, 32'hDEAD_BEEF, 0);

    // 2: isolated corrupted word
    step("t2", 1, 32'h25, 0);
    chk("t2.pulse", 32'(err_pulse), 32'd1);
    chk("t2.ecnt", 32'(err_count), 32'd1);
    step("t2", 1, 32'h49, 0);
    chk("t2.pulse_low", 32'(err_pulse), 32'd0);
    chk("t2.wcnt", word_count, 32'd2);
    chk("t2.locked", 32'(locked), 32'd1);

    // 3: ERR_LIMIT consecutive errors drop lock, then relock
    for (int i = 0; i < EL; i++) step("t3.bad", 1, m_exp ^ 32'h100, 0);
    chk("t3.unlocked", 32'(locked), 32'd0);
    chk("t3.ecnt", 32'(err_count), 32'd4);
    step("t3", 1, 32'h1, 0);
    step("t3", 1, 32'h2, 0);
    step("t3", 1, 32'h4, 0);
    step("t3", 1, 32'h9, 0);
    step("t3", 1, 32'h12, 0);
    chk("t3.relocked", 32'(locked), 32'd1);

    // 4: all-ones never seeds; a miss during acquisition restarts it
    sync_reset();
    step("t4.ones", 1, 32'hFFFF_FFFF, 0);
    chk("t4.exp0", expected, 32'd0);
    step("t4", 1, 32'h1, 0);
    step("t4", 1, 32'h2, 0);
    step("t4", 1, 32'h7, 0);
    chk("t4.reseed", expected, 32'hF);
    for (int i = 0; i < LC - 1; i++) step("t4.acq", 1, m_exp, 0);
    chk("t4.not_yet", 32'(locked), 32'd0);
    step("t4.acq", 1, m_exp, 0);
    chk("t4.locked", 32'(locked), 32'd1);

    // 5: saturation of a narrow err_count, clear racing a mismatch
    for (int i = 0; i < 20; i++) begin
      step("t5.bad", 1, m_exp ^ 32'h8000_0000, 0);
      step("t5.good", 1, m_exp, 0);
    end
    chk("t5.sat", 32'(err_count), 32'hF);
    step("t5.clr", 1, m_exp ^ 32'h1, 1);
    chk("t5.clr_ecnt", 32'(err_count), 32'd0);
    chk("t5.clr_pulse", 32'(err_pulse), 32'd1);
    chk("t5.clr_lock", 32'(locked), 32'd1);

    // random streams with gaps, corruption, reseeds and clears
    src = m_exp;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 3) src = $urandom;
      v = ($urandom_range(0, 3) != 0);
      if (v) begin
        r = $urandom_range(0, 99);
        if (r < 10) d = src ^ ($urandom | 32'h1);
        else if (r < 12) d = 32'hFFFF_FFFF;
        else d = src;
        src = ref_next(src);
      end else d = $urandom;
      c = ($urandom_range(0, 39) == 0);
      step("rand", v, d, c);
    end

    // 6: asynchronous reset between edges while locked
    sync_reset();
    step("t6", 1, 32'h1, 0);
    step("t6", 1, 32'h2, 0);
    step("t6", 1, 32'h4, 0);
    step("t6", 1, 32'h9, 0);
    step("t6", 1, 32'h12, 0);
    step("t6", 1, 32'h25, 0);
    #2 rst = 1'b1;
    #1;
    chk("t6.locked", 32'(locked), 32'd0);
    chk("t6.ecnt", 32'(err_count), 32'd0);
    chk("t6.wcnt", word_count, 32'd0);
    chk("t6.exp", expected, 32'd0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    step("t6.idle", 1, 32'h1, 0);
    chk("t6.reseed", expected, 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
